// File: rtl/mc_alu.sv
// mc_alu: multi-cycle ALU. Logic, shift and add/sub ops complete in one
// registered cycle. Multiply and divide iterate one bit per cycle into the
// HI/LO registers and use a start/busy/done handshake.
module mc_alu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [3:0]       flags,
  output logic             dz,
  output logic             busy,
  output logic             done
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned CW  = $clog2(WIDTH + 1);
  localparam int unsigned W2  = 2 * WIDTH;
  localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(1);
  localparam logic [W2-1:0]    ONE_2W = W2'(1);

  typedef enum logic [3:0] {
    OP_PASS = 4'h0, OP_ADD  = 4'h1, OP_SUB  = 4'h2, OP_MULT = 4'h3,
    OP_DIV  = 4'h4, OP_AND  = 4'h5, OP_OR   = 4'h6, OP_NOR  = 4'h7,
    OP_SRL  = 4'h8, OP_SLL  = 4'h9, OP_SRA  = 4'hA, OP_LUI  = 4'hB,
    OP_MFHI = 4'hC, OP_MFLO = 4'hD, OP_MTHI = 4'hE, OP_MTLO = 4'hF
  } op_e;

  typedef enum logic {
    S_IDLE,
    S_ITER
  } state_e;

  // Architectural and iteration registers
  state_e           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_y, r_hi, r_lo;
  logic [3:0]       r_flags;
  logic             r_dz, r_busy, r_done;
  logic [WIDTH-1:0] r_hreg;    // partial product upper half / partial remainder
  logic [WIDTH-1:0] r_lreg;    // multiplier / dividend shifting into quotient
  logic [WIDTH-1:0] r_dv;      // multiplicand / divisor magnitude
  logic [WIDTH-1:0] r_a_save;  // raw dividend, returned as HI on divide by zero
  logic             r_is_div, r_neg_q, r_neg_r, r_bzero;

  // Single-cycle datapath
  op_e              w_op;
  logic [SHW-1:0]   w_sh;
  logic [WIDTH:0]   w_sum, w_diff;
  logic [WIDTH-1:0] w_y;
  logic             w_c, w_v, w_z, w_n, w_upd_y, w_long;

  assign w_op   = op_e'(op);
  assign w_sh   = a[SHW-1:0];
  assign w_sum  = {1'b0, a} + {1'b0, b};
  assign w_diff = {1'b0, a} - {1'b0, b};
  assign w_long = (w_op == OP_MULT) || (w_op == OP_DIV);

  // Operand magnitudes for the iterative unit
  logic [WIDTH-1:0] w_amag, w_bmag;
  assign w_amag = (sgn && a[WIDTH-1]) ? (~a) + ONE_W : a;
  assign w_bmag = (sgn && b[WIDTH-1]) ? (~b) + ONE_W : b;

  // Iteration step and final sign correction
  logic [WIDTH:0]   w_msum, w_dshr, w_dtrial;
  logic [W2-1:0]    w_prod, w_prod_fix;
  logic [WIDTH-1:0] w_q_fix, w_r_fix;

  assign w_msum     = {1'b0, r_hreg} + {1'b0, (r_lreg[0] ? r_dv : '0)};
  assign w_dshr     = {r_hreg, r_lreg[WIDTH-1]};
  assign w_dtrial   = w_dshr - {1'b0, r_dv};
  assign w_prod     = {r_hreg, r_lreg};
  assign w_prod_fix = r_neg_q ? (~w_prod) + ONE_2W : w_prod;
  assign w_q_fix    = r_neg_q ? (~r_lreg) + ONE_W : r_lreg;
  assign w_r_fix    = r_neg_r ? (~r_hreg) + ONE_W : r_hreg;

  // Result and flag selection for the single-cycle operations
  always_comb begin
    w_y     = b;
    w_c     = r_flags[3];
    w_v     = r_flags[0];
    w_upd_y = 1'b1;
    case (w_op)
      OP_PASS: w_y = b;
      OP_ADD: begin
        w_y = w_sum[WIDTH-1:0];
        w_c = w_sum[WIDTH];
        w_v = sgn ? ((a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]))
                  : w_sum[WIDTH];
      end
      OP_SUB: begin
        w_y = w_diff[WIDTH-1:0];
        w_c = w_diff[WIDTH];
        w_v = sgn ? ((a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]))
                  : w_diff[WIDTH];
      end
      OP_AND:  w_y = a & b;
      OP_OR:   w_y = a | b;
      OP_NOR:  w_y = ~(a | b);
      OP_SRL:  w_y = b >> w_sh;
      OP_SLL:  w_y = b << w_sh;
      OP_SRA:  w_y = $signed(b) >>> w_sh;
      OP_LUI:  w_y = b << (WIDTH / 2);
      OP_MFHI: w_y = r_hi;
      OP_MFLO: w_y = r_lo;
      default: w_upd_y = 1'b0;
    endcase
    w_z = (w_y == '0);
    w_n = w_y[WIDTH-1];
  end

  // Control FSM plus all architectural state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_y      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_flags  <= '0;
      r_dz     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hreg   <= '0;
      r_lreg   <= '0;
      r_dv     <= '0;
      r_a_save <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_bzero  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_long) begin
              r_state  <= S_ITER;
              r_busy   <= 1'b1;
              r_cnt    <= '0;
              r_is_div <= (w_op == OP_DIV);
              r_hreg   <= '0;
              r_lreg   <= w_amag;
              r_dv     <= w_bmag;
              r_a_save <= a;
              r_neg_q  <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
              r_neg_r  <= sgn & a[WIDTH-1];
              r_bzero  <= (b == '0);
            end else begin
              r_done <= 1'b1;
              if (w_upd_y) begin
                r_y     <= w_y;
                r_flags <= {w_c, w_z, w_n, w_v};
              end
              if (w_op == OP_MTHI) r_hi <= a;
              if (w_op == OP_MTLO) r_lo <= a;
            end
          end
        end
        S_ITER: begin
          if (r_cnt == CW'(WIDTH)) begin
            // Final cycle: all WIDTH steps are done, apply signs and publish
            if (!r_is_div) begin
              {r_hi, r_lo} <= w_prod_fix;
            end else if (r_bzero) begin
              r_lo <= '1;
              r_hi <= r_a_save;
              r_dz <= 1'b1;
            end else begin
              r_lo <= w_q_fix;
              r_hi <= w_r_fix;
              r_dz <= 1'b0;
            end
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
            if (!r_is_div) begin
              r_hreg <= w_msum[WIDTH:1];
              r_lreg <= {w_msum[0], r_lreg[WIDTH-1:1]};
            end else if (!w_dtrial[WIDTH]) begin
              r_hreg <= w_dtrial[WIDTH-1:0];
              r_lreg <= {r_lreg[WIDTH-2:0], 1'b1};
            end else begin
              r_hreg <= w_dshr[WIDTH-1:0];
              r_lreg <= {r_lreg[WIDTH-2:0], 1'b0};
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign y     = r_y;
  assign hi    = r_hi;
  assign lo    = r_lo;
  assign flags = r_flags;
  assign dz    = r_dz;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule
